// File: rtl/reg_dump_reader.sv
// reg_dump_reader: streams the whole register file out as bytes.
// Each register is read through port A, latched once in its LOAD cycle, then
// sent as four bytes over a valid/ready byte interface. Register 0 always
// reads as zero. done pulses for one cycle once the whole dump is finished.
module reg_dump_reader #(
    parameter int NUM_REGS  = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  ra,
    input  logic [31:0] busa,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t      state;
    logic [4:0]  idx;
    logic [1:0]  byte_cnt;
    logic [31:0] shreg;
    logic [31:0] word;
    logic        xfer;

    // Register 0 is hardwired zero, whatever the bank drives.
    assign word = (idx == 5'd0) ? 32'h0000_0000 : busa;
    assign xfer = tx_valid && tx_ready;

    // Dump sequencer. tx_data always holds the byte currently offered; shreg
    // holds the latched word and shifts so the next byte sits at a fixed slot.
    // done rises on the edge that leaves DONE, one cycle after the last transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 5'd0;
            ra       <= 5'd0;
            byte_cnt <= 2'd0;
            shreg    <= 32'h0000_0000;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= 5'd0;
                        ra    <= 5'd0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shreg    <= word;
                    byte_cnt <= 2'd0;
                    tx_data  <= MSB_FIRST ? word[31:24] : word[7:0];
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        if (byte_cnt != 2'd3) begin
                            byte_cnt <= byte_cnt + 2'd1;
                            if (MSB_FIRST) begin
                                tx_data <= shreg[23:16];
                                shreg   <= {shreg[23:0], 8'h00};
                            end else begin
                                tx_data <= shreg[15:8];
                                shreg   <= {8'h00, shreg[31:8]};
                            end
                        end else begin
                            tx_valid <= 1'b0;
                            if (idx == LAST_IDX) begin
                                state <= DONE;
                            end else begin
                                idx   <= idx + 5'd1;
                                ra    <= idx + 5'd1;
                                state <= LOAD;
                            end
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: three instances (32 regs MSB-first, 32 regs
// LSB-first, 2 regs MSB-first) reading a shared behavioural register bank.
// Expected byte streams come from the bank contents and byte-order rule.
module tb_reg_dump_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    logic [31:0] bank [32];

    logic s0 = 1'b0, r0 = 1'b1, v0, b0, d0;
    logic s1 = 1'b0, r1 = 1'b1, v1, b1, d1;
    logic s2 = 1'b0, r2 = 1'b1, v2, b2, d2;
    logic [4:0]  a0, a1, a2;
    logic [7:0]  t0, t1, t2;
    logic [31:0] w0, w1, w2;

    assign w0 = bank[a0];
    assign w1 = bank[a1];
    assign w2 = bank[a2];

    reg_dump_reader #(.NUM_REGS(32), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(s0), .ra(a0), .busa(w0),
        .tx_data(t0), .tx_valid(v0), .tx_ready(r0), .busy(b0), .done(d0));
    reg_dump_reader #(.NUM_REGS(32), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .start(s1), .ra(a1), .busa(w1),
        .tx_data(t1), .tx_valid(v1), .tx_ready(r1), .busy(b1), .done(d1));
    reg_dump_reader #(.NUM_REGS(2), .MSB_FIRST(1'b1)) dut_two (
        .clk(clk), .rst_n(rst_n), .start(s2), .ra(a2), .busa(w2),
        .tx_data(t2), .tx_valid(v2), .tx_ready(r2), .busy(b2), .done(d2));

    logic [7:0] q0[$], q1[$], q2[$], exp_q[$];
    int dn0 = 0, dn1 = 0, dn2 = 0, viol0 = 0, ramax2 = 0;
    logic ps0 = 1'b0;
    logic [7:0] pd0 = 8'h00;

    // Collect accepted bytes and done pulses; flag any change of an offered
    // byte while the sink is stalling.
    always @(posedge clk) begin
        if (!rst_n) begin
            ps0 = 1'b0;
        end else begin
            if (ps0 && (!v0 || t0 !== pd0)) viol0++;
            if (v0 && r0) q0.push_back(t0);
            if (d0) dn0++;
            ps0 = v0 && !r0;
            pd0 = t0;
            if (v1 && r1) q1.push_back(t1);
            if (d1) dn1++;
            if (v2 && r2) q2.push_back(t2);
            if (d2) dn2++;
            if (int'(a2) > ramax2) ramax2 = int'(a2);
        end
    end

    // Reference stream: registers in ascending order, reg 0 reads zero.
    task automatic build_exp(input int n, input bit msb);
        logic [31:0] w;
        exp_q.delete();
        for (int r = 0; r < n; r++) begin
            w = (r == 0) ? 32'h0 : bank[r];
            for (int b = 0; b < 4; b++)
                exp_q.push_back(msb ? w[31-8*b -: 8] : w[8*b +: 8]);
        end
    endtask

    function automatic int first_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return -2;
        foreach (a[i]) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({a0, t0, v0, b0, d0} !== 16'h0) begin
            errs++;
            $display("FAIL reset_values: got %h want 0000", {a0, t0, v0, b0, d0});
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_dump_ready();
        int fv = -1, fd = -1, busy_bad = 0, diff;
        for (int i = 0; i < 32; i++) bank[i] = i;
        build_exp(32, 1'b1);
        q0.delete(); dn0 = 0; r0 = 1'b1;
        s0 = 1'b1;
        for (int c = 1; c <= 175; c++) begin
            tick();
            if (c == 1) s0 = 1'b0;
            if (v0 && fv < 0) fv = c;
            if (d0 && fd < 0) fd = c;
            if ((c <= 161 && !b0) || (c >= 162 && b0)) busy_bad++;
        end
        checks++;
        if (fv != 2) begin errs++; $display("FAIL first_valid_cycle: got %0d want 2", fv); end
        checks++;
        if (fd != 162) begin errs++; $display("FAIL done_cycle: got %0d want 162", fd); end
        checks++;
        if (busy_bad != 0) begin errs++; $display("FAIL busy_window: got %0d bad cycles want 0", busy_bad); end
        checks++;
        if (dn0 != 1) begin errs++; $display("FAIL done_count: got %0d want 1", dn0); end
        checks++;
        if (q0.size() != 128) begin errs++; $display("FAIL byte_count: got %0d want 128", q0.size()); end
        diff = first_diff(q0, exp_q);
        checks++;
        if (diff != -1) begin errs++; $display("FAIL byte_stream: first diff at %0d want none", diff); end
    endtask

    task automatic test_lsb_first();
        int diff;
        for (int i = 0; i < 32; i++) bank[i] = 32'hDEAD_BEEF;
        build_exp(32, 1'b0);
        q1.delete(); dn1 = 0;
        s1 = 1'b1;
        tick();
        s1 = 1'b0;
        for (int c = 0; c < 400 && dn1 == 0; c++) tick();
        tick();
        checks++;
        if (q1.size() < 8 || {q1[0], q1[1], q1[2], q1[3]} !== 32'h0) begin
            errs++; $display("FAIL lsb_reg0: got size %0d want reg0 bytes 00 00 00 00", q1.size());
        end
        checks++;
        if (q1.size() < 8 || {q1[4], q1[5], q1[6], q1[7]} !== 32'hEFBEADDE) begin
            errs++; $display("FAIL lsb_reg1: got size %0d want EF BE AD DE", q1.size());
        end
        diff = first_diff(q1, exp_q);
        checks++;
        if (diff != -1) begin errs++; $display("FAIL lsb_stream: first diff at %0d want none", diff); end
        checks++;
        if (dn1 != 1 || b1 !== 1'b0) begin
            errs++; $display("FAIL lsb_done: got dones=%0d busy=%b want 1/0", dn1, b1);
        end
    endtask

    task automatic test_stall();
        int hold = 0, diff;
        for (int i = 0; i < 32; i++) bank[i] = $urandom;
        build_exp(32, 1'b1);
        q0.delete(); dn0 = 0; viol0 = 0;
        s0 = 1'b1;
        tick();
        s0 = 1'b0;
        for (int c = 0; c < 3000 && dn0 == 0; c++) begin
            if (q0.size() == 22 && hold < 10) begin
                r0 = 1'b0;
                hold++;
            end else begin
                r0 = 1'($urandom_range(0, 1));
            end
            tick();
        end
        r0 = 1'b1;
        tick();
        checks++;
        if (viol0 != 0) begin errs++; $display("FAIL stall_stable: got %0d changes want 0", viol0); end
        diff = first_diff(q0, exp_q);
        checks++;
        if (diff != -1) begin errs++; $display("FAIL stall_stream: first diff at %0d want none", diff); end
        checks++;
        if (dn0 != 1) begin errs++; $display("FAIL stall_done: got %0d want 1", dn0); end
    endtask

    task automatic test_restart_ignored();
        int diff;
        for (int i = 0; i < 32; i++) bank[i] = $urandom;
        build_exp(32, 1'b1);
        q0.delete(); dn0 = 0; r0 = 1'b1;
        s0 = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            s0 = (c == 3 || c == 50 || c == 161);
        end
        checks++;
        if (dn0 != 1) begin errs++; $display("FAIL restart_done: got %0d want 1", dn0); end
        checks++;
        if (q0.size() != 128) begin errs++; $display("FAIL restart_count: got %0d want 128", q0.size()); end
        diff = first_diff(q0, exp_q);
        checks++;
        if (diff != -1) begin errs++; $display("FAIL restart_stream: first diff at %0d want none", diff); end
        checks++;
        if (b0 !== 1'b0) begin errs++; $display("FAIL restart_idle: got busy=%b want 0", b0); end
    endtask

    task automatic test_reset_mid();
        int diff;
        for (int i = 0; i < 32; i++) bank[i] = $urandom;
        build_exp(32, 1'b1);
        q0.delete(); dn0 = 0; r0 = 1'b1;
        s0 = 1'b1;
        tick();
        s0 = 1'b0;
        for (int c = 0; c < 400 && q0.size() != 29; c++) tick();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({a0, t0, v0, b0, d0} !== 16'h0) begin
            errs++; $display("FAIL async_reset: got %h want 0000", {a0, t0, v0, b0, d0});
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        checks++;
        if (dn0 != 0 || q0.size() != 29 || b0 !== 1'b0) begin
            errs++; $display("FAIL abort: got dones=%0d bytes=%0d busy=%b want 0/29/0", dn0, q0.size(), b0);
        end
        q0.delete(); dn0 = 0;
        s0 = 1'b1;
        tick();
        s0 = 1'b0;
        for (int c = 0; c < 400 && dn0 == 0; c++) tick();
        checks++;
        if (q0.size() != 128) begin errs++; $display("FAIL redump_count: got %0d want 128", q0.size()); end
        diff = first_diff(q0, exp_q);
        checks++;
        if (diff != -1) begin errs++; $display("FAIL redump_stream: first diff at %0d want none", diff); end
    endtask

    task automatic test_two_regs();
        int x8 = -1, dc = -1, diff;
        for (int i = 0; i < 32; i++) bank[i] = $urandom;
        build_exp(2, 1'b1);
        q2.delete(); dn2 = 0; ramax2 = 0;
        s2 = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1) s2 = 1'b0;
            if (q2.size() == 8 && x8 < 0) x8 = c;
            if (d2 && dc < 0) dc = c;
        end
        diff = first_diff(q2, exp_q);
        checks++;
        if (diff != -1) begin errs++; $display("FAIL two_stream: got size %0d diff %0d want 8 bytes match", q2.size(), diff); end
        checks++;
        if (ramax2 != 1) begin errs++; $display("FAIL two_ra: got max ra %0d want 1", ramax2); end
        checks++;
        if (x8 < 0 || dc != x8 + 1) begin errs++; $display("FAIL two_done_timing: got done %0d want %0d", dc, x8 + 1); end
        checks++;
        if (dn2 != 1 || b2 !== 1'b0) begin errs++; $display("FAIL two_done_count: got %0d busy=%b want 1/0", dn2, b2); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = 32'h0;
        test_reset();
        test_dump_ready();
        test_lsb_first();
        test_stall();
        test_restart_ignored();
        test_reset_mid();
        test_two_regs();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
